pixel_tap_sampler: RTL and testbench

- Upstream feeder for the frequency analyzers.
- Counts pixels within each video line and captures the 8-bit intensity at three fixed tap indices.
- Converts each captured value to a clean binary sample using threshold hysteresis plus line-count debounce.
- Emits the three sample bits with a once-per-line strobe, from which frequency_analyzer_manager's analyzers derive blink frequency.

---
 rtl/pixel_tap_pkg.sv | 23 ++
 rtl/tap_hysteresis_filter.sv | 45 ++++
 rtl/pixel_tap_sampler.sv | 122 ++++++++++++
 tb/tb_pixel_tap_sampler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pixel_tap_pkg.sv
// Shared types and defaults for the pixel tap sampler: line FSM states, tap/threshold defaults.
// No timing of its own; no flow control.
package pixel_tap_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } line_state_t;

  localparam int DEF_LINE_LENGTH    = 1024;
  localparam int DEF_TAP0_INDEX     = 15;
  localparam int DEF_TAP1_INDEX     = 511;
  localparam int DEF_TAP2_INDEX     = 1023;
  localparam int DEF_THRESHOLD_HIGH = 160;
  localparam int DEF_THRESHOLD_LOW  = 96;
  localparam int DEF_STABLE_LINES   = 2;

  function automatic int ctr_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tap_hysteresis_filter.sv
// Threshold vote with hysteresis plus line-count debounce; sample updates on the edge that completes a line.
// Latency one cycle from line_complete; no backpressure, evaluated only when line_complete is high.
module tap_hysteresis_filter
  import pixel_tap_pkg::*;
#(
  parameter int THRESHOLD_HIGH = DEF_THRESHOLD_HIGH,
  parameter int THRESHOLD_LOW  = DEF_THRESHOLD_LOW,
  parameter int STABLE_LINES   = DEF_STABLE_LINES
) (
  input  logic       pixel_clock,
  input  logic       clear,
  input  logic       line_complete,
  input  logic [7:0] value,
  output logic       sample
);

  localparam int DW = ctr_width(STABLE_LINES);

  logic [DW-1:0] stable_count;
  logic          vote;

  // Values between the thresholds keep the current sample.
  always_comb begin
    vote = sample;
    if (value >= 8'(THRESHOLD_HIGH)) vote = 1'b1;
    else if (value <= 8'(THRESHOLD_LOW)) vote = 1'b0;
  end

  always_ff @(posedge pixel_clock) begin
    if (clear) begin
      sample       <= 1'b0;
      stable_count <= '0;
    end else if (line_complete) begin
      if (vote == sample) begin
        stable_count <= '0;
      end else if (stable_count == DW'(STABLE_LINES - 1)) begin
        sample       <= ~sample;
        stable_count <= '0;
      end else begin
        stable_count <= stable_count + DW'(1);
      end
    end
  end

endmodule

// File: rtl/pixel_tap_sampler.sv
// Counts pixels per line, captures three tap intensities and emits filtered sample bits once per complete line.
// Strobe one cycle after the final pixel; no backpressure, pixels accepted whenever enable is high.
module pixel_tap_sampler
  import pixel_tap_pkg::*;
#(
  parameter int LINE_LENGTH    = DEF_LINE_LENGTH,
  parameter int TAP0_INDEX     = DEF_TAP0_INDEX,
  parameter int TAP1_INDEX     = DEF_TAP1_INDEX,
  parameter int TAP2_INDEX     = DEF_TAP2_INDEX,
  parameter int THRESHOLD_HIGH = DEF_THRESHOLD_HIGH,
  parameter int THRESHOLD_LOW  = DEF_THRESHOLD_LOW,
  parameter int STABLE_LINES   = DEF_STABLE_LINES
) (
  input  logic        pixel_clock,
  input  logic        clear,
  input  logic [7:0]  data,
  input  logic        enable,
  input  logic        line_start,
  output logic [23:0] tap_value,
  output logic [2:0]  tap_sample,
  output logic        sample_strobe,
  output logic        line_short,
  output logic        line_overrun
);

  localparam int CW = ctr_width(LINE_LENGTH);

  function automatic int tap_index(input int n);
    return (n == 0) ? TAP0_INDEX : (n == 1) ? TAP1_INDEX : TAP2_INDEX;
  endfunction

  line_state_t   state, state_next;
  logic [CW-1:0] count, count_next;
  logic [CW-1:0] idx;
  logic          accept;
  logic          line_complete;
  logic          set_short;
  logic          set_overrun;
  logic [23:0]   filt_value;

  always_ff @(posedge pixel_clock) begin
    if (clear) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
    end
  end

  always_comb begin
    state_next    = state;
    count_next    = count;
    idx           = count;
    accept        = 1'b0;
    line_complete = 1'b0;
    set_short     = 1'b0;
    set_overrun   = 1'b0;
    if (enable) begin
      if (line_start) begin
        accept     = 1'b1;
        idx        = '0;
        count_next = CW'(1);
        state_next = ACTIVE;
        set_short  = (state == ACTIVE);
      end else begin
        case (state)
          ACTIVE: begin
            accept     = 1'b1;
            count_next = count + CW'(1);
            if (count == CW'(LINE_LENGTH - 1)) begin
              state_next    = DONE;
              line_complete = 1'b1;
            end
          end
          DONE:    set_overrun = 1'b1;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge pixel_clock) begin
    if (clear) begin
      tap_value     <= '0;
      sample_strobe <= 1'b0;
      line_short    <= 1'b0;
      line_overrun  <= 1'b0;
    end else begin
      sample_strobe <= line_complete;
      if (set_short)   line_short   <= 1'b1;
      if (set_overrun) line_overrun <= 1'b1;
      for (int n = 0; n < 3; n++) begin
        if (accept && idx == CW'(tap_index(n))) tap_value[8*n +: 8] <= data;
      end
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_tap
    localparam int TI = (g == 0) ? TAP0_INDEX : (g == 1) ? TAP1_INDEX : TAP2_INDEX;

    // A tap on the last pixel is not yet registered when the line completes.
    if (TI == LINE_LENGTH - 1) begin : g_bypass
      assign filt_value[8*g +: 8] = data;
    end else begin : g_reg
      assign filt_value[8*g +: 8] = tap_value[8*g +: 8];
    end

    tap_hysteresis_filter #(
      .THRESHOLD_HIGH(THRESHOLD_HIGH),
      .THRESHOLD_LOW (THRESHOLD_LOW),
      .STABLE_LINES  (STABLE_LINES)
    ) u_filter (
      .pixel_clock  (pixel_clock),
      .clear        (clear),
      .line_complete(line_complete),
      .value        (filt_value[8*g +: 8]),
      .sample       (tap_sample[g])
    );
  end

endmodule

// File: tb/tb_pixel_tap_sampler.sv
// Drives two samplers (debounce 1 and 2 lines) with directed and random lines, checking every cycle against a line-level model.
module tb_pixel_tap_sampler;

  localparam int LL = 16;
  localparam int TAPS [3] = '{2, 7, 15};
  localparam int TH = 160;
  localparam int TL = 96;

  logic       clk = 1'b0;
  logic       clear = 1'b1;
  logic [7:0] data = '0;
  logic       enable = 1'b0;
  logic       line_start = 1'b0;

  logic [23:0] tv_a, tv_b;
  logic [2:0]  ts_a, ts_b;
  logic        st_a, st_b, sh_a, sh_b, ov_a, ov_b;

  int checks = 0;
  int errors = 0;

  bit         line_open, line_full;
  int         pos;
  logic [7:0] m_tap [3];
  bit         m_samp [2][3];
  int         m_cnt [2][3];
  bit         m_short, m_over, m_strobe;

  always #5 clk = ~clk;

  pixel_tap_sampler #(
    .LINE_LENGTH(LL), .TAP0_INDEX(2), .TAP1_INDEX(7), .TAP2_INDEX(15),
    .THRESHOLD_HIGH(TH), .THRESHOLD_LOW(TL), .STABLE_LINES(1)
  ) dut_a (
    .pixel_clock(clk), .clear(clear), .data(data), .enable(enable), .line_start(line_start),
    .tap_value(tv_a), .tap_sample(ts_a), .sample_strobe(st_a),
    .line_short(sh_a), .line_overrun(ov_a)
  );

  pixel_tap_sampler #(
    .LINE_LENGTH(LL), .TAP0_INDEX(2), .TAP1_INDEX(7), .TAP2_INDEX(15),
    .THRESHOLD_HIGH(TH), .THRESHOLD_LOW(TL), .STABLE_LINES(2)
  ) dut_b (
    .pixel_clock(clk), .clear(clear), .data(data), .enable(enable), .line_start(line_start),
    .tap_value(tv_b), .tap_sample(ts_b), .sample_strobe(st_b),
    .line_short(sh_b), .line_overrun(ov_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] samp_vec(input int k);
    return {m_samp[k][2], m_samp[k][1], m_samp[k][0]};
  endfunction

  task automatic check_all();
    logic [23:0] tv;
    tv = {m_tap[2], m_tap[1], m_tap[0]};
    chk("strobe_a", 32'(st_a), 32'(m_strobe));
    chk("strobe_b", 32'(st_b), 32'(m_strobe));
    chk("tap_value_a", 32'(tv_a), 32'(tv));
    chk("tap_value_b", 32'(tv_b), 32'(tv));
    chk("tap_sample_a", 32'(ts_a), 32'(samp_vec(0)));
    chk("tap_sample_b", 32'(ts_b), 32'(samp_vec(1)));
    chk("line_short_a", 32'(sh_a), 32'(m_short));
    chk("line_short_b", 32'(sh_b), 32'(m_short));
    chk("line_overrun_a", 32'(ov_a), 32'(m_over));
    chk("line_overrun_b", 32'(ov_b), 32'(m_over));
  endtask

  task automatic model_reset();
    line_open = 0; line_full = 0; pos = 0;
    m_short = 0; m_over = 0; m_strobe = 0;
    for (int n = 0; n < 3; n++) begin
      m_tap[n] = '0;
      for (int k = 0; k < 2; k++) begin
        m_samp[k][n] = 0;
        m_cnt[k][n]  = 0;
      end
    end
  endtask

  // A complete line yields one vote per tap; a vote must disagree for k+1 lines in a row to flip.
  task automatic finish_line();
    bit v;
    m_strobe = 1;
    for (int k = 0; k < 2; k++) begin
      for (int n = 0; n < 3; n++) begin
        if (m_tap[n] >= TH) v = 1;
        else if (m_tap[n] <= TL) v = 0;
        else v = m_samp[k][n];
        if (v == m_samp[k][n]) m_cnt[k][n] = 0;
        else begin
          m_cnt[k][n]++;
          if (m_cnt[k][n] >= k + 1) begin
            m_samp[k][n] = v;
            m_cnt[k][n]  = 0;
          end
        end
      end
    end
  endtask

  task automatic take(input logic [7:0] d);
    for (int n = 0; n < 3; n++) if (pos == TAPS[n]) m_tap[n] = d;
    pos++;
    if (pos == LL) begin
      line_full = 1;
      finish_line();
    end
  endtask

  task automatic step(input bit clr, input bit en, input logic [7:0] d, input bit ls);
    @(negedge clk);
    check_all();
    m_strobe = 0;
    if (clr) model_reset();
    else if (en) begin
      if (ls) begin
        if (line_open && !line_full) m_short = 1;
        line_open = 1; line_full = 0; pos = 0;
        take(d);
      end else if (line_open && line_full) m_over = 1;
      else if (line_open) take(d);
    end
    clear = clr; enable = en; data = d; line_start = ls;
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'($urandom), 1'($urandom));
  endtask

  // val < 0 selects random pixels; t0 >= 0 forces the tap 0 pixel.
  task automatic send_line(input int npix, input bit gaps, input int val, input int t0);
    logic [7:0] d;
    for (int i = 0; i < npix; i++) begin
      d = (val < 0) ? 8'($urandom) : 8'(val);
      if (i == TAPS[0] && t0 >= 0) d = 8'(t0);
      step(0, 1, d, i == 0);
      if (gaps && (i % 2 == 1)) gap(3);
    end
  endtask

  initial begin
    int seq [5];
    seq = '{200, 200, 128, 50, 50};
    model_reset();
    repeat (2) @(negedge clk);

    // reset values, then one flat bright line
    step(1, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    send_line(LL, 0, 200, -1);
    gap(2);

    // tap0 hysteresis/debounce sequence, back-to-back lines
    step(1, 0, 8'h00, 0);
    for (int l = 0; l < 5; l++) send_line(LL, 0, -1, seq[l]);
    gap(2);

    // aborted line then a full one
    send_line(9, 0, -1, -1);
    send_line(LL, 0, -1, -1);

    // overrun pixels after a complete line
    for (int i = 0; i < 4; i++) step(0, 1, 8'($urandom), 0);
    send_line(LL, 0, -1, -1);

    // clear mid-line; later pixels without line_start are ignored
    send_line(5, 0, 255, -1);
    step(1, 1, 8'hFF, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 8'hEE, 0);

    // enable gaps vs gap-free
    step(1, 0, 8'h00, 0);
    for (int l = 0; l < 3; l++) send_line(LL, 1, -1, seq[l]);
    step(1, 0, 8'h00, 0);
    for (int l = 0; l < 3; l++) send_line(LL, 0, -1, seq[l]);
    gap(1);

    // random mix of lengths, gaps and overruns
    for (int l = 0; l < 40; l++) begin
      send_line(($urandom_range(0, 3) == 0) ? $urandom_range(1, LL - 1) : LL,
                1'($urandom), -1, -1);
      if ($urandom_range(0, 4) == 0) step(0, 1, 8'($urandom), 0);
      if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
    end
    gap(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
